// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store initiator for a word-wide BRAM port with
//               active-low strobes; handles lane extraction, sign/zero
//               extension and read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wr_n_o,
  output logic                  mem_rd_n_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        legal;
  logic        misaligned;

  // Upper address bits are deliberately dropped so addresses wrap.
  logic        addr_unused;
  assign addr_unused = &{1'b0, addr_i[31:WORDS+2]};

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    if (we_i) begin
      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    end else begin
      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
              (funct3_i == 3'b100) || (funct3_i == 3'b101);
    end
    if (funct3_i[1:0] == 2'b01) begin
      misaligned = addr_i[0];
    end else if (funct3_i[1:0] == 2'b10) begin
      misaligned = (addr_i[1:0] != 2'b00);
    end
  end

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (f3 == 3'b000) begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0000;
      rdata_o    <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_wr_n_o <= 1'b1;
      mem_rd_n_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            mem_addr_o <= addr_i[WORDS+1:2];
            funct3_q   <= funct3_i;
            lane_q     <= addr_i[1:0];
            wdata_q    <= wdata_i[15:0];
            busy_o     <= 1'b1;
            if (!legal || misaligned) begin
              state <= FAULT;
            end else if (!we_i) begin
              state      <= LOAD;
              mem_rd_n_o <= 1'b0;
            end else if (funct3_i == 3'b010) begin
              state      <= STORE;
              mem_wr_n_o <= 1'b0;
              mem_data_o <= wdata_i;
            end else begin
              state      <= RMW_RD;
              mem_rd_n_o <= 1'b0;
            end
          end
        end
        LOAD: begin
          mem_rd_n_o <= 1'b1;
          rdata_o    <= load_extract(mem_data_i, funct3_q, lane_q);
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        STORE: begin
          mem_wr_n_o <= 1'b1;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        RMW_RD: begin
          // Read strobe drops on the same edge the write strobe rises, so the two never overlap.
          mem_rd_n_o <= 1'b1;
          mem_wr_n_o <= 1'b0;
          mem_data_o <= store_merge(mem_data_i, funct3_q, lane_q, wdata_q);
          state      <= RMW_WR;
        end
        RMW_WR: begin
          mem_wr_n_o <= 1'b1;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        FAULT: begin
          done_o <= 1'b1;
          err_o  <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_rd_n_o <= 1'b1;
          mem_wr_n_o <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-wide BRAM port: turns RV32I load/store requests (byte address, funct3 size/sign) into word accesses with active-low read/write strobes.
- Sits between the multicycle control/datapath and the data memory.
- Handles byte-lane extraction and sign/zero extension on loads, and read-modify-write for SB/SH.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- WORDS, 10, memory word-address width (2^WORDS words)
- DATA_WIDTH, 32, data width; only 32 is supported

Ports:
- clk_i  in  1  clock, posedge; memory side samples strobes on negedge
- reset_i  in  1  synchronous, active-high reset
- req_i  in  1  start access; sampled only in IDLE
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I funct3 (size/sign)
- addr_i  in  32  byte address
- wdata_i  in  32  store data (right-justified)
- rdata_o  out  32  extended load result
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; misaligned/illegal access
- busy_o  out  1  high whenever state != IDLE
- mem_addr_o  out  WORDS  word address = addr_i[WORDS+1:2]
- mem_data_o  out  32  write data to memory
- mem_wr_n_o  out  1  write enable, active low
- mem_rd_n_o  out  1  read enable, active low
- mem_data_i  in  32  memory read data, valid at the posedge after the strobed negedge

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on reset_i.
- All outputs are registered. Reset values: state=IDLE, mem_wr_n_o=1, mem_rd_n_o=1, done_o=0, err_o=0, busy_o=0, rdata_o=0, mem_addr_o=0, mem_data_o=0.
- Reset mid-operation: strobes go inactive on the reset edge and state returns to IDLE, with no done pulse.
  - An SB/SH aborted before its write cycle leaves memory unchanged.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, FAULT.
- Address and lane handling:
  - addr_i[31:WORDS+2] is ignored, so addresses wrap.
  - Lane = addr_i[1:0], little-endian: lane0 = bits 7:0.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
- IDLE, with req_i sampled at edge E0 (addr/funct3/wdata/we latched):
  - Illegal or misaligned -> FAULT; no strobe asserted.
  - Load -> LOAD, mem_rd_n_o=0.
  - SW -> STORE, mem_wr_n_o=0, mem_data_o=wdata_i.
  - SB/SH -> RMW_RD, mem_rd_n_o=0.
- LOAD at E1: mem_rd_n_o=1; rdata_o = selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); done_o=1 for the cycle after E1; -> IDLE.
- STORE at E1: mem_wr_n_o=1, done_o=1, -> IDLE.
- RMW_RD at E1: mem_rd_n_o=0->1, mem_wr_n_o=0, mem_data_o = mem_data_i with the target lane(s) replaced by wdata_i[7:0] or [15:0]; -> RMW_WR.
- RMW_WR at E2: mem_wr_n_o=1, done_o=1, -> IDLE.
- FAULT at E1: done_o=1, err_o=1, rdata_o unchanged, -> IDLE.
- Latencies from the req sample edge to done_o: 1 edge (load, SW, fault); 2 edges (SB/SH).
- A new request is accepted in the cycle done_o is high (state is already IDLE), giving back-to-back operation.
- req_i is ignored while busy_o=1.
- rd_n and wr_n are never low in the same cycle.
- mem_addr_o is held stable for the whole access.
- err_o=0 on every non-fault done.

Test Plan:
- Memory word 5 = 0x8899AABB. LB addr 0x15 -> rdata 0xFFFFFFAA, done 1 edge after req; LBU 0x17 -> 0x00000088; LH 0x16 -> 0xFFFF8899; LW 0x14 -> 0x8899AABB.
- SB addr 0x15, wdata 0x123456CC, on word 5 = 0x8899AABB -> one rd cycle, one wr cycle with data 0x8899CCBB; done 2 edges after req; memory reads back 0x8899CCBB.
- SH 0x16, wdata 0x0000BEEF -> word 5 = 0xBEEFAABB. SW 0x14, wdata 0xDEADBEEF -> a single wr cycle only.
- Misaligned LW 0x16, misaligned SH 0x13, funct3=011 load -> done+err one edge later, both strobes stay high, memory unchanged.
- Back-to-back: issue SW then LW to the same address in consecutive done cycles -> LW returns the new data; req_i pulsed while busy -> ignored.
- Assert reset_i during RMW_RD of an SB -> strobes high the next cycle, no done, word unchanged; the next LW succeeds.
